// File: rtl/ifmap_burst_reader_if.sv
// rtl/ifmap_burst_reader_if.sv - read address/data bus between ifmap_burst_reader and its slave
interface ifmap_burst_reader_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic [3:0]    arburst;
  logic          arready;
  logic [DW-1:0] rdata;
  logic          rlast;
  logic          rvalid;

  modport master (
    output araddr, arvalid, arburst,
    input  arready, rdata, rlast, rvalid
  );

  modport slave (
    input  araddr, arvalid, arburst,
    output arready, rdata, rlast, rvalid
  );
endinterface

// File: rtl/ifmap_burst_reader.sv
// rtl/ifmap_burst_reader.sv - splits an ifmap fetch into power-of-two read bursts and forwards beats
// Optional rlast consistency checking is built when RD_CHK_EN is defined.
module ifmap_burst_reader #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int CW      = 24,
  parameter int MAX_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [CW-1:0]        len_words,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  ifmap_burst_reader_if.master bus,
  output logic [DW-1:0]        dout,
  output logic                 dout_valid
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    cur_addr;
  logic [CW-1:0]    rem;
  logic [MAX_LOG:0] beat_cnt;
  logic [3:0]       burst_log;
  logic [CW-1:0]    burst_len;
  logic             beat;
  logic             last_beat;

  // Largest power of two not above rem, capped at 2^MAX_LOG.
  always_comb begin
    burst_log = '0;
    for (int i = 1; i <= MAX_LOG; i++) begin
      if (rem >= (CW'(1) << i)) burst_log = 4'(i);
    end
  end

  assign burst_len = CW'(1) << burst_log;
  assign beat      = (state == DATA) && bus.rvalid;
  assign last_beat = beat && (CW'(beat_cnt) == burst_len - CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.arvalid = 1'b0;
    bus.araddr  = '0;
    bus.arburst = '0;
    busy        = (state != IDLE);
    done        = (state == FIN);
    case (state)
      IDLE: if (start) state_nxt = (len_words == '0) ? FIN : ADDR;
      ADDR: begin
        bus.araddr  = cur_addr;
        bus.arburst = burst_log;
        if (bus.arready) begin
          bus.arvalid = 1'b1;
          state_nxt   = DATA;
        end
      end
      DATA: if (last_beat) state_nxt = (rem == burst_len) ? FIN : ADDR;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      rem        <= '0;
      beat_cnt   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= beat;
      if (beat) dout <= bus.rdata;
      case (state)
        IDLE: if (start) begin
          cur_addr <= base_addr;
          rem      <= len_words;
        end
        // Clearing while waiting for arready is harmless; only the handshake cycle matters.
        ADDR: beat_cnt <= '0;
        DATA: if (beat) begin
          beat_cnt <= beat_cnt + (MAX_LOG+1)'(1);
          if (last_beat) begin
            cur_addr <= cur_addr + AW'(burst_len);
            rem      <= rem - burst_len;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RD_CHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                                err_q <= 1'b0;
    else if (beat && (bus.rlast != last_beat)) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_rlast;

  assign unused_rlast = bus.rlast;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_ifmap_burst_reader.sv
// tb/tb_ifmap_burst_reader.sv - randomized bench for ifmap_burst_reader against a burst-list model
`timescale 1ns/1ps
module tb_ifmap_burst_reader;
  localparam int DW = 32, AW = 32, CW = 24, MAX_LOG = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] len_words;
  logic          busy, done, err, dout_valid;
  logic [DW-1:0] dout;

  ifmap_burst_reader_if #(.AW(AW), .DW(DW)) bus ();

  ifmap_burst_reader #(.DW(DW), .AW(AW), .CW(CW), .MAX_LOG(MAX_LOG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len_words(len_words),
    .busy(busy), .done(done), .err(err), .bus(bus), .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] exp_addr[$];
  int            exp_log[$];
  logic [DW-1:0] exp_data[$];
  logic [DW-1:0] pend_data[$];
  bit            pend_last[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected request list and word stream; slave memory holds mem[a] = a.
  task automatic build_model(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    int remw, n, lg;
    a = base;
    remw = len;
    exp_addr.delete(); exp_log.delete(); exp_data.delete();
    while (remw > 0) begin
      n = 1;
      lg = 0;
      while (lg < MAX_LOG && 2 * n <= remw) begin
        n = n * 2;
        lg++;
      end
      exp_addr.push_back(a);
      exp_log.push_back(lg);
      for (int i = 0; i < n; i++) exp_data.push_back(a + AW'(i));
      a = a + AW'(n);
      remw = remw - n;
    end
  endtask

  task automatic run_cmd(input logic [AW-1:0] base, input int len, input int gap, input bit stray);
    int cyc, busy_cyc, done_cyc, n_done, gap_cnt, n;
    cyc = 1; busy_cyc = 0; done_cyc = -1; n_done = 0; gap_cnt = 0;
    build_model(base, len);
    pend_data.delete(); pend_last.delete();
    start = 1'b1; base_addr = base; len_words = CW'(len);
    @(negedge clk);
    forever begin
      if (busy) busy_cyc++;
      if (dout_valid) begin
        if (exp_data.size() == 0) check("extra_dout", 1, 0);
        else check("dout", dout, exp_data.pop_front());
      end
      if (n_done > 0) begin
        check("busy_after_done", busy, 0);
        check("done_width", done, 0);
        break;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        check("done_drain", exp_data.size(), 0);
        check("err_clear", err, 0);
        if (len > 0) check("done_with_last", dout_valid, 1);
      end
      start = stray && busy && (done || cyc == 3);
      base_addr = 32'hBAD0;
      len_words = 8;
      bus.arready = (pend_data.size() == 0) && (gap_cnt >= gap);
      if (pend_data.size() == 0) gap_cnt++;
      if (pend_data.size() > 0 && $urandom_range(3) != 0) begin
        bus.rvalid = 1'b1;
        bus.rdata  = pend_data.pop_front();
        bus.rlast  = pend_last.pop_front();
      end else if (pend_data.size() == 0 && $urandom_range(3) == 0) begin
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hDEAD_BEEF;
        bus.rlast  = 1'($urandom_range(1));
      end else begin
        bus.rvalid = 1'b0;
        bus.rdata  = $urandom;
        bus.rlast  = 1'b0;
      end
      #1;
      if (bus.arvalid) begin
        check("arvalid_needs_arready", bus.arready, 1);
        if (exp_addr.size() == 0) check("extra_req", 1, 0);
        else begin
          check("araddr", bus.araddr, exp_addr.pop_front());
          check("arburst", bus.arburst, exp_log.pop_front());
        end
        n = 1 << bus.arburst;
        for (int i = 0; i < n; i++) begin
          pend_data.push_back(bus.araddr + AW'(i));
          pend_last.push_back(i == n - 1);
        end
        gap_cnt = 0;
      end
      if (cyc > 3000) begin
        check("timeout", 1, 0);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.arready = 1'b0;
    check("done_count", n_done, 1);
    check("reqs_left", exp_addr.size(), 0);
    if (n_done > 0) check("busy_cycles", busy_cyc, done_cyc);
    if (len == 0) check("len0_done_lat", done_cyc, 1);
  endtask

  task automatic reset_mid_burst();
    int k;
    start = 1'b1; base_addr = '0; len_words = 32; bus.arready = 1'b1; bus.rvalid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 10; k++) begin
      #1;
      if (bus.arvalid) break;
      @(negedge clk);
    end
    check("rst_seq_req", k < 10, 1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.rvalid = 1'b1; bus.rdata = DW'(i); bus.rlast = 1'b0;
      @(negedge clk);
    end
    check("rst_seq_dv", dout_valid, 1);
    check("rst_seq_dout", dout, 4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_dout_valid", dout_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst_ignore_beats", dout_valid, 0);
      check("rst_stay_idle", busy, 0);
    end
    bus.rvalid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len_words = '0;
    bus.arready = 1'b1; bus.rvalid = 1'b0; bus.rdata = '0; bus.rlast = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_arvalid", bus.arvalid, 0);
    check("reset_araddr", bus.araddr, 0);
    check("reset_arburst", bus.arburst, 0);
    check("reset_dout_valid", dout_valid, 0);
    check("reset_dout", dout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(32'h100, 16, 0, 1'b0);
    run_cmd(32'h0, 21, 0, 1'b0);
    run_cmd(32'h40, 40, 3, 1'b0);
    run_cmd(32'h77, 0, 0, 1'b0);
    run_cmd(32'h0, 32, 0, 1'b1);
    run_cmd(32'h200, 8, 0, 1'b0);
    run_cmd(32'hFFFF_FFF8, 20, 1, 1'b0);
    for (int i = 0; i < 25; i++)
      run_cmd($urandom, int'($urandom_range(70)), int'($urandom_range(3)), 1'($urandom_range(1)));

    reset_mid_burst();

`ifdef RD_CHK_EN
    start = 1'b1; base_addr = 32'h300; len_words = 4; bus.arready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("chk_req", bus.arvalid, 1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rvalid = 1'b1; bus.rlast = (i == 2); bus.rdata = DW'(i);
      @(negedge clk);
      check("err_sticky", err, i >= 2);
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
    repeat (3) @(negedge clk);
    check("err_hold", err, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("err_reset", err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ifmap_burst_reader.md
# ifmap_burst_reader

Read-master controller for the input-buffer AXI-style read bus. It accepts one command of {base word address, word count} and splits it into power-of-two bursts no longer than 2^MAX_LOG beats. It issues each burst on the address channel, counts returning beats, and forwards every beat as a registered word stream to the input buffer write port. It is the only master on the bus and sequences all ifmap tile fetches.

## Interface
- DW, 32, data width
- AW, 32, word-address width
- CW, 24, word-count width
- MAX_LOG, 4, log2 of max burst beats (≤15; arburst is 4 bits)
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  command strobe, accepted only when busy=0
- base_addr  in  AW  first word address, sampled with start
- len_words  in  CW  total words, sampled with start
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- err  out  1  sticky protocol error (see Configuration)
- araddr  out  AW  burst start word address
- arvalid  out  1  burst request
- arburst  out  4  log2 of burst length
- arready  in  1  bus can accept a request
- rdata  in  DW  read data
- rlast  in  1  slave's final-beat flag
- rvalid  in  1  read beat valid
- dout  out  DW  forwarded word
- dout_valid  out  1  dout qualifier; no backpressure

## Operation
- States: IDLE, ADDR, DATA, FIN.
- IDLE: when start=1, latch base_addr into cur_addr and len_words into rem, set busy=1, then:
  - go to FIN if len_words=0;
  - otherwise go to ADDR.
- ADDR: burst length L is the largest power of two ≤ rem, capped at 2^MAX_LOG; arburst=log2(L).
  - arvalid is driven only while arready=1, as a single-cycle pulse; the handshake completes that cycle.
  - On handshake: araddr=cur_addr, beat counter cleared, go to DATA.
- DATA: each rvalid=1 cycle is one beat; beat counter increments.
  - On beat L: cur_addr += L (mod 2^AW), rem -= L.
  - Then go to ADDR if rem≠0, else FIN.
- FIN: done=1 for exactly one cycle, busy=0, go to IDLE.
- Every beat in DATA is forwarded: dout←rdata and dout_valid←1 on the next clock.
- rvalid outside DATA is ignored and not forwarded.
- Burst completion is decided by the beat count only. rlast does not end a burst.
- start while busy=1 is ignored, including in the FIN cycle.
- All arithmetic is unsigned. rem never underflows because L ≤ rem.

## Timing
- Reset (rst_n=0 at a clock edge): state=IDLE; busy, done, err, arvalid, dout_valid =0; araddr, arburst, dout =0.
- Reset mid-burst aborts the command immediately; further beats after reset are ignored.
- start at edge t: busy=1 from t+1. ADDR is entered at t+1, so the earliest arvalid is cycle t+1.
- Address outputs are combinational from state, cur_addr, and rem; arvalid = (state==ADDR) & arready.
- Data path latency is one cycle: rvalid at edge k gives dout_valid=1 at k+1.
- The last beat of the last burst at edge k gives FIN at k+1. done is asserted in the same cycle as the final dout_valid, and busy drops at k+2.
- len_words=0: done=1 in cycle t+1 (FIN), busy=0 at t+2, no bus activity.
- Back-to-back bursts: the next arvalid is possible in the cycle after the final beat.
- A new start is accepted in the first cycle where busy=0.

## Configuration
- RD_CHK_EN defined: in DATA, each beat is compared against the slave's flag.
  - rlast=1 on a beat other than beat L sets err.
  - rlast=0 on beat L sets err.
  - err is sticky until reset; the data path is unaffected.
- RD_CHK_EN undefined: the check logic is not generated, err is tied to 0, and rlast is unused.

## Test plan
- base_addr=0x100, len=16, slave memory mem[i]=i → one request: araddr=0x100, arburst=4. dout = 0x100..0x10F on 16 consecutive valid cycles; done coincides with the 0x10F beat.
- base=0, len=21 → requests (0, arburst 4), (16, arburst 2), (20, arburst 0); dout = 0..20 in order; exactly one done.
- base=0x40, len=40, arready low for 3 cycles before each request → requests issued at 0x40, 0x50, 0x60 with arburst 4, 4, 3. arvalid is never high while arready=0; 40 beats total.
- len=0 → done at t+1, arvalid never asserted, busy high for exactly one cycle.
- Second start (len=8) issued during a len=32 command → ignored; after done, a new start base=0x200, len=8 produces one arburst=3 request at 0x200.
- Assert rst_n=0 in the middle of a burst (after 5 beats) → next cycle: busy=0, arvalid=0, dout_valid=0; subsequent beats produce no dout_valid.
- With RD_CHK_EN defined, rlast asserted on beat 3 of a 4-beat burst → err=1 from the next cycle and it remains 1.
